keypad_scan_ctrl: RTL and testbench
===================================

# keypad_scan_ctrl

Matrix-keypad scan controller for the RISC-V cache SoC peripheral subsystem. It sits between the 4x4 keypad pins (`keypad_col`/`keypad_row`) and the GPIO/peripheral register block. It drives the columns one at a time and samples the rows. Each press is debounced; one code per press is pushed into a small FIFO that the CPU pops, and an interrupt is raised while the FIFO is non-empty.

## Interface
- `COL_CYCLES`, 100_000: clock cycles each column is driven (1 ms at 100 MHz); ≥4.
- `DEBOUNCE_SCANS`, 3: consecutive identical full scans needed to accept a press or a release; 1..15.
- `FIFO_DEPTH`, 4: key FIFO entries; power of two, ≥2.
- `axi_aclk`  in  1  clock.
- `axi_areset`  in  1  asynchronous, active-high reset.
- `keypad_col`  out  4  column drive, active-low one-hot.
- `keypad_row`  in  4  row sense, active-low; pulled high externally.
- `scan_en`  in  1  1 = scanning enabled.
- `key_code`  out  4  FIFO head: row*4+col.
- `key_ascii`  out  8  FIFO head mapped to ASCII.
  - Row0: '1','2','3','A'
  - Row1: '4','5','6','B'
  - Row2: '7','8','9','C'
  - Row3: '0','F','E','D'
- `key_valid`  out  1  FIFO non-empty.
- `key_ready`  in  1  pop; a pop occurs when `key_valid & key_ready` in a cycle.
- `ovf`  out  1  sticky: a press was dropped because the FIFO was full.
- `ovf_clr`  in  1  clears `ovf`.
- `irq`  out  1  = `key_valid & irq_en`.
- `irq_en`  in  1  interrupt enable.

## Operation
- Rows pass through a 2-flop synchronizer before any use.
- **Column sequencer**
  - Cycle counter `cc` runs 0..COL_CYCLES-1 with width $clog2(COL_CYCLES).
  - Column index `ci` runs 0..3. It advances when `cc` wraps, and 3 wraps to 0.
  - `keypad_col = ~(4'b1 << ci)`.
  - Rows are sampled at `cc == COL_CYCLES-1`, which allows settling plus synchronizer delay.
- **Per-scan accumulator**
  - Tracks the number of low rows over the 4 columns (saturating at 2) and the (row, col) of the last hit.
  - At the sample of column 3 the scan completes, and the result is one of:
    - NONE: 0 hits.
    - SINGLE(code): exactly 1 hit.
    - MULTI: 2 or more hits, covering ghosting and chords.
  - The accumulator then clears.
- **FSM**, evaluated once per completed scan; the debounce counter `dc` is 4 bits.
  - IDLE:
    - SINGLE(k) → PRESS_DB with `cand=k`, `dc=1`.
    - Otherwise stay in IDLE.
  - PRESS_DB:
    - SINGLE(cand) → `dc++`.
    - When `dc` reaches DEBOUNCE_SCANS, push `cand` and go to HELD.
    - With DEBOUNCE_SCANS=1, the push happens on the IDLE transition itself and the FSM goes straight to HELD.
    - Any other result → IDLE with `dc=0`.
  - HELD:
    - NONE → REL_DB with `dc=1`.
    - SINGLE(cand), SINGLE(other) or MULTI → stay in HELD. No repeat and no second key until release.
  - REL_DB:
    - NONE → `dc++`.
    - When `dc` reaches DEBOUNCE_SCANS → IDLE.
    - Any non-NONE result → HELD with `dc=0`.
- **FIFO**
  - FIFO_DEPTH entries; pointers carry one extra wrap bit for full/empty.
  - A push while full drops the code and sets `ovf`.
  - A push and a pop in the same cycle while full: the pop frees the slot, the push succeeds, and `ovf` is not set.
  - A push and a pop while empty: the push is stored and `key_valid` rises the next cycle. There is no fall-through.
  - `ovf_clr` coinciding with a dropped push: the set wins.
- **`scan_en` = 0**
  - `cc`, `ci`, the accumulator and the FSM are held in reset state, and `keypad_col = 4'hF`.
  - FIFO contents and `ovf` are preserved, and pops still work.
  - On re-enable, scanning starts at column 0 with `cc = 0`.

## Timing
- Reset values:
  - `keypad_col = 4'hF`
  - `key_valid = 0`, `key_code = 0`, `key_ascii = 8'h31`
  - `ovf = 0`, `irq = 0`
  - FSM = IDLE; `cc`, `ci`, `dc` and the FIFO pointers are all 0.
- Reset applied mid-press returns everything to these values immediately (asynchronous), and the FIFO is emptied.
- One full scan = 4*COL_CYCLES cycles.
- Press latency:
  - The push occurs 1 cycle after the column-3 sample of the DEBOUNCE_SCANS-th matching scan.
  - `key_valid` is high the cycle after the push.
- Minimum accepted press length ≈ DEBOUNCE_SCANS*4*COL_CYCLES. With the defaults that is 12 ms, below the 15 ms key hold used by the SoC bench.
- `key_code` and `key_ascii` are driven combinationally from the FIFO head and are stable while `key_valid = 1` and no pop occurs.
- `irq` is registered: it follows `key_valid & irq_en` with 1 cycle of latency.

## Test plan
All scenarios use COL_CYCLES=8, DEBOUNCE_SCANS=3, FIFO_DEPTH=4. The bench models the matrix: `row[r]` is low when `col[c]` is low and key (r,c) is pressed.
1. Reset → `keypad_col = F`. After release of reset, `keypad_col` cycles E, D, B, 7 with 8 cycles each; `key_valid = 0`.
2. Press '6' (r1,c2) for 16 scans → exactly one push: `key_code = 6`, `key_ascii = 8'h36`, `key_valid` high 3 scans + 2 cycles after the first matching scan; `irq = 1` when `irq_en = 1`.
3. Press '6' for only 2 scans → no push; `key_valid` stays 0.
4. Enter sequence 6,4,8,2,9,1,D with `key_ready = 0` → the first 4 codes 6,4,8,2 are stored and `ovf = 1`; after popping 4 times the FIFO is empty; `ovf_clr` → `ovf = 0`.
5. Hold '2' and '5' together → MULTI, no push. Press '1', then add '3' while in HELD → single push of 0 ('1'), and nothing further until all keys are released for 3 scans.
6. Assert `axi_areset` during PRESS_DB and again with 2 codes queued → `key_valid = 0` and `keypad_col = F` immediately; a new press after reset produces a normal push.

Source files
------------

// File: rtl/keypad_scan_ctrl.sv
// 4x4 matrix keypad scanner: column drive, row sync, per-scan debounce,
// and a small key FIFO with sticky overflow and a level interrupt.
module keypad_scan_ctrl #(
   parameter int COL_CYCLES     = 100_000,
   parameter int DEBOUNCE_SCANS = 3,
   parameter int FIFO_DEPTH     = 4
) (
   input  logic       axi_aclk,
   input  logic       axi_areset,
   output logic [3:0] keypad_col,
   input  logic [3:0] keypad_row,
   input  logic       scan_en,
   output logic [3:0] key_code,
   output logic [7:0] key_ascii,
   output logic       key_valid,
   input  logic       key_ready,
   output logic       ovf,
   input  logic       ovf_clr,
   output logic       irq,
   input  logic       irq_en
);

   localparam int            CW     = $clog2(COL_CYCLES);
   localparam int            AW     = $clog2(FIFO_DEPTH);
   localparam logic [CW-1:0] CC_MAX = CW'(COL_CYCLES - 1);
   localparam logic [CW-1:0] CC_ONE = CW'(1);
   localparam logic [AW:0]   P_ONE  = (AW+1)'(1);
   localparam logic [3:0]    DB_N   = 4'(DEBOUNCE_SCANS);

   typedef enum logic [1:0] {
      S_IDLE,
      S_PRESS_DB,
      S_HELD,
      S_REL_DB
   } state_t;

   logic [3:0]    r_row_s1;
   logic [3:0]    r_row_s2;
   logic          r_run;
   logic [CW-1:0] r_cc;
   logic [1:0]    r_ci;
   logic [1:0]    r_hits;
   logic [3:0]    r_last;
   state_t        r_state;
   logic [3:0]    r_cand;
   logic [3:0]    r_dc;
   logic          r_push;
   logic [3:0]    r_mem [FIFO_DEPTH];
   logic [AW:0]   r_wp;
   logic [AW:0]   r_rp;
   logic          r_ovf;
   logic          r_irq;

   logic          w_act;
   logic          w_sample;
   logic          w_done;
   logic [2:0]    w_nlow;
   logic [1:0]    w_lrow;
   logic [2:0]    w_hsum;
   logic [1:0]    w_hits;
   logic [3:0]    w_code;
   logic          w_none;
   logic          w_single;
   logic          w_empty;
   logic          w_full;
   logic          w_pop;
   logic          w_wr;
   logic          w_drop;
   logic [3:0]    w_head;

   always_ff @(posedge axi_aclk or posedge axi_areset) begin
      if (axi_areset) begin
         r_row_s1 <= 4'hF;
         r_row_s2 <= 4'hF;
         r_run    <= 1'b0;
      end else begin
         r_row_s1 <= keypad_row;
         r_row_s2 <= r_row_s1;
         r_run    <= 1'b1;
      end
   end

   // Scanning only runs one cycle after reset release and while enabled
   assign w_act      = r_run & scan_en;
   assign keypad_col = w_act ? ~(4'b0001 << r_ci) : 4'hF;
   assign w_sample   = w_act && (r_cc == CC_MAX);
   assign w_done     = w_sample && (r_ci == 2'd3);

   always_comb begin
      w_nlow = 3'd0;
      w_lrow = 2'd0;
      for (int i = 0; i < 4; i++) begin
         if (!r_row_s2[i]) begin
            w_nlow = w_nlow + 3'd1;
            w_lrow = 2'(i);
         end
      end
   end

   assign w_hsum   = {1'b0, r_hits} + w_nlow;
   assign w_hits   = (w_hsum >= 3'd2) ? 2'd2 : w_hsum[1:0];
   assign w_code   = (w_nlow != 3'd0) ? {w_lrow, r_ci} : r_last;
   assign w_none   = (w_hits == 2'd0);
   assign w_single = (w_hits == 2'd1);

   always_ff @(posedge axi_aclk or posedge axi_areset) begin
      if (axi_areset) begin
         r_cc   <= '0;
         r_ci   <= 2'd0;
         r_hits <= 2'd0;
         r_last <= 4'd0;
      end else if (!w_act) begin
         r_cc   <= '0;
         r_ci   <= 2'd0;
         r_hits <= 2'd0;
         r_last <= 4'd0;
      end else if (w_sample) begin
         r_cc <= '0;
         r_ci <= r_ci + 2'd1;
         if (r_ci == 2'd3) begin
            r_hits <= 2'd0;
            r_last <= 4'd0;
         end else begin
            r_hits <= w_hits;
            r_last <= w_code;
         end
      end else begin
         r_cc <= r_cc + CC_ONE;
      end
   end

   always_ff @(posedge axi_aclk or posedge axi_areset) begin
      if (axi_areset) begin
         r_state <= S_IDLE;
         r_cand  <= 4'd0;
         r_dc    <= 4'd0;
         r_push  <= 1'b0;
      end else begin
         r_push <= 1'b0;
         if (!w_act) begin
            r_state <= S_IDLE;
            r_cand  <= 4'd0;
            r_dc    <= 4'd0;
         end else if (w_done) begin
            unique case (r_state)
               S_IDLE: begin
                  if (w_single) begin
                     r_cand <= w_code;
                     if (DB_N == 4'd1) begin
                        r_push  <= 1'b1;
                        r_state <= S_HELD;
                        r_dc    <= 4'd0;
                     end else begin
                        r_state <= S_PRESS_DB;
                        r_dc    <= 4'd1;
                     end
                  end
               end
               S_PRESS_DB: begin
                  if (w_single && (w_code == r_cand)) begin
                     if (r_dc + 4'd1 == DB_N) begin
                        r_push  <= 1'b1;
                        r_state <= S_HELD;
                        r_dc    <= 4'd0;
                     end else begin
                        r_dc <= r_dc + 4'd1;
                     end
                  end else begin
                     r_state <= S_IDLE;
                     r_dc    <= 4'd0;
                  end
               end
               S_HELD: begin
                  if (w_none) begin
                     if (DB_N == 4'd1) begin
                        r_state <= S_IDLE;
                        r_dc    <= 4'd0;
                     end else begin
                        r_state <= S_REL_DB;
                        r_dc    <= 4'd1;
                     end
                  end
               end
               S_REL_DB: begin
                  if (w_none) begin
                     if (r_dc + 4'd1 == DB_N) begin
                        r_state <= S_IDLE;
                        r_dc    <= 4'd0;
                     end else begin
                        r_dc <= r_dc + 4'd1;
                     end
                  end else begin
                     r_state <= S_HELD;
                     r_dc    <= 4'd0;
                  end
               end
            endcase
         end
      end
   end

   assign w_empty = (r_wp == r_rp);
   assign w_full  = (r_wp[AW] != r_rp[AW]) &&
                    (r_wp[AW-1:0] == r_rp[AW-1:0]);
   assign w_pop   = ~w_empty & key_ready;
   // A same-cycle pop frees the slot, so a push into a full FIFO still lands
   assign w_wr    = r_push & (~w_full | w_pop);
   assign w_drop  = r_push & w_full & ~w_pop;

   always_ff @(posedge axi_aclk) begin
      if (w_wr) begin
         r_mem[r_wp[AW-1:0]] <= r_cand;
      end
   end

   always_ff @(posedge axi_aclk or posedge axi_areset) begin
      if (axi_areset) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_ovf <= 1'b0;
         r_irq <= 1'b0;
      end else begin
         if (w_wr) begin
            r_wp <= r_wp + P_ONE;
         end
         if (w_pop) begin
            r_rp <= r_rp + P_ONE;
         end
         if (w_drop) begin
            r_ovf <= 1'b1;
         end else if (ovf_clr) begin
            r_ovf <= 1'b0;
         end
         r_irq <= ~w_empty & irq_en;
      end
   end

   assign w_head    = w_empty ? 4'd0 : r_mem[r_rp[AW-1:0]];
   assign key_code  = w_head;
   assign key_valid = ~w_empty;
   assign ovf       = r_ovf;
   assign irq       = r_irq;

   always_comb begin
      key_ascii = 8'h31;
      case (w_head)
         4'd0:  key_ascii = 8'h31;
         4'd1:  key_ascii = 8'h32;
         4'd2:  key_ascii = 8'h33;
         4'd3:  key_ascii = 8'h41;
         4'd4:  key_ascii = 8'h34;
         4'd5:  key_ascii = 8'h35;
         4'd6:  key_ascii = 8'h36;
         4'd7:  key_ascii = 8'h42;
         4'd8:  key_ascii = 8'h37;
         4'd9:  key_ascii = 8'h38;
         4'd10: key_ascii = 8'h39;
         4'd11: key_ascii = 8'h43;
         4'd12: key_ascii = 8'h30;
         4'd13: key_ascii = 8'h46;
         4'd14: key_ascii = 8'h45;
         4'd15: key_ascii = 8'h44;
         default: key_ascii = 8'h31;
      endcase
   end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: keypad matrix model, scan-level debounce
// and FIFO reference, directed scenarios plus randomized key activity.
module tb_keypad_scan_ctrl;

   localparam int CC = 8;
   localparam int DS = 3;
   localparam int FD = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] col;
   logic [3:0] row;
   logic       scan_en = 1'b1;
   logic [3:0] key_code;
   logic [7:0] key_ascii;
   logic       key_valid;
   logic       key_ready = 1'b0;
   logic       ovf;
   logic       ovf_clr = 1'b0;
   logic       irq;
   logic       irq_en = 1'b0;
   logic [15:0] keys = 16'h0;

   int checks = 0;
   int errors = 0;

   int q[$];
   bit m_ovf    = 1'b0;
   bit m_locked = 1'b0;
   int m_run    = 0;
   int m_key    = 0;
   int m_quiet  = 0;
   int m_pend   = -1;

   keypad_scan_ctrl #(
      .COL_CYCLES(CC),
      .DEBOUNCE_SCANS(DS),
      .FIFO_DEPTH(FD)
   ) dut (
      .axi_aclk(clk),
      .axi_areset(rst),
      .keypad_col(col),
      .keypad_row(row),
      .scan_en(scan_en),
      .key_code(key_code),
      .key_ascii(key_ascii),
      .key_valid(key_valid),
      .key_ready(key_ready),
      .ovf(ovf),
      .ovf_clr(ovf_clr),
      .irq(irq),
      .irq_en(irq_en)
   );

   always #5 clk = ~clk;

   // Pressed key (r,c) pulls row r low while column c is driven low
   always_comb begin
      row = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (!col[c] && keys[r*4+c]) row[r] = 1'b0;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   function automatic logic [7:0] ascii_of(input int k);
      string s;
      s = "123A456B789C0FED";
      return s[k];
   endfunction

   task automatic chk(input string tag, input logic [7:0] obs,
                      input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_status(input string tag);
      int hc;
      hc = (q.size() > 0) ? q[0] : 0;
      chk({tag, ".valid"}, 8'(key_valid), 8'(q.size() > 0));
      chk({tag, ".code"}, 8'(key_code), 8'(hc));
      chk({tag, ".ascii"}, key_ascii, ascii_of(hc));
      chk({tag, ".ovf"}, 8'(ovf), 8'(m_ovf));
      chk({tag, ".irq"}, 8'(irq), 8'((q.size() > 0) && irq_en));
   endtask

   task automatic model_reset_fsm();
      m_locked = 1'b0;
      m_run    = 0;
      m_quiet  = 0;
   endtask

   // Returns 1 when the pending code was dropped on a full FIFO
   function automatic bit model_push();
      bit drop;
      drop = 1'b0;
      if (m_pend >= 0) begin
         if (q.size() < FD) q.push_back(m_pend);
         else drop = 1'b1;
         m_pend = -1;
      end
      return drop;
   endfunction

   task automatic model_scan(input logic [15:0] mask);
      int n;
      int k;
      n = $countones(mask);
      k = -1;
      for (int i = 0; i < 16; i++) if (mask[i]) k = i;
      if (!m_locked) begin
         if (n == 1 && m_run > 0 && k == m_key) m_run++;
         else if (n == 1 && m_run == 0) begin
            m_key = k;
            m_run = 1;
         end else m_run = 0;
         if (m_run == DS) begin
            m_pend   = m_key;
            m_locked = 1'b1;
            m_quiet  = 0;
            m_run    = 0;
         end
      end else begin
         if (n == 0) m_quiet++;
         else m_quiet = 0;
         if (m_quiet == DS) begin
            m_locked = 1'b0;
            m_quiet  = 0;
         end
      end
   endtask

   task automatic sync_scan();
      int n;
      n = 0;
      #1;
      while (col !== 4'hE && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("sync", 8'(col), 8'h0E);
   endtask

   // One full scan with keys held; clr: 1 = mid-scan, 2 = on push edge
   task automatic scan(input logic [15:0] mask, input int npop,
                       input int clr, input bit p0);
      int popped;
      logic [3:0] ec;
      bit drop;
      popped = 0;
      keys = mask;
      for (int i = 0; i < 32; i++) begin
         ec = 4'hF;
         ec[i/8] = 1'b0;
         chk("col", 8'(col), 8'(ec));
         if (i == 2) chk_status("scan");
         key_ready = (i == 0 && p0) ||
                     (i >= 3 && popped < npop && q.size() > 0);
         if (key_ready && q.size() > 0)
            chk("pop_head", 8'(key_code), 8'(q[0]));
         ovf_clr = (clr == 2 && i == 0) || (clr == 1 && i == 10);
         @(negedge clk);
         if (key_ready && q.size() > 0) begin
            void'(q.pop_front());
            popped++;
         end
         drop = (i == 0) ? model_push() : 1'b0;
         if (drop) m_ovf = 1'b1;
         else if (ovf_clr) m_ovf = 1'b0;
      end
      key_ready = 1'b0;
      ovf_clr   = 1'b0;
      model_scan(mask);
   endtask

   task automatic scans(input logic [15:0] mask, input int n);
      for (int i = 0; i < n; i++) scan(mask, 0, 0, 1'b0);
   endtask

   task automatic tap(input int k);
      scans(16'(1) << k, DS);
      scans(16'h0, DS);
   endtask

   task automatic do_reset();
      #2;
      rst = 1'b1;
      #1;
      chk("rst.col", 8'(col), 8'h0F);
      chk("rst.valid", 8'(key_valid), 8'h00);
      chk("rst.code", 8'(key_code), 8'h00);
      chk("rst.ascii", key_ascii, 8'h31);
      chk("rst.ovf", 8'(ovf), 8'h00);
      chk("rst.irq", 8'(irq), 8'h00);
      keys = 16'h0;
      q.delete();
      m_ovf  = 1'b0;
      m_pend = -1;
      model_reset_fsm();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      sync_scan();
   endtask

   task automatic scan_off();
      bit drop;
      scan_en = 1'b0;
      #1;
      chk("off.col", 8'(col), 8'h0F);
      @(negedge clk);
      drop = model_push();
      if (drop) m_ovf = 1'b1;
      repeat (4) @(negedge clk);
      chk("off.col2", 8'(col), 8'h0F);
      chk_status("off");
      if (q.size() > 0) begin
         chk("off.pop_head", 8'(key_code), 8'(q[0]));
         key_ready = 1'b1;
         @(negedge clk);
         key_ready = 1'b0;
         void'(q.pop_front());
      end
      model_reset_fsm();
      scan_en = 1'b1;
      sync_scan();
   endtask

   initial begin
      logic [15:0] m;
      int ty;
      int hold;
      int k1;
      int k2;

      repeat (3) @(negedge clk);
      chk("init.col", 8'(col), 8'h0F);
      chk_status("init");
      rst = 1'b0;
      sync_scan();

      // idle scans, then a long press of '6' with interrupts on
      scans(16'h0, 2);
      irq_en = 1'b1;
      scans(16'(1) << 6, 16);
      scans(16'h0, DS);
      scan(16'h0, 1, 0, 1'b0);

      // too short to be accepted
      scans(16'(1) << 6, 2);
      scans(16'h0, DS + 1);

      // overflow: 6,4,8,2,9,1,D with no pops
      irq_en = 1'b0;
      tap(6); tap(4); tap(9); tap(1);
      tap(10); tap(0); tap(15);
      scan(16'h0, 4, 1, 1'b0);
      scan(16'h0, 0, 0, 1'b0);

      // full FIFO: push with same-cycle pop, then drop with clear
      tap(3); tap(7); tap(11); tap(15);
      scans(16'(1) << 5, DS);
      scan(16'h0, 0, 0, 1'b1);
      scans(16'h0, DS);
      scans(16'(1) << 9, DS);
      scan(16'h0, 0, 2, 1'b0);
      scans(16'h0, DS);
      scan(16'h0, 4, 1, 1'b0);

      // chord / ghost, then a second key added while held
      scans(16'h0022, 5);
      scans(16'h0, DS);
      scans(16'h0001, 4);
      scans(16'h0005, 4);
      scans(16'h0004, 3);
      scans(16'h0, DS);
      scan(16'h0, 2, 0, 1'b0);

      // async reset mid-debounce and with codes queued
      scans(16'(1) << 5, 2);
      do_reset();
      tap(0); tap(1);
      scan(16'h0, 0, 0, 1'b0);
      do_reset();
      irq_en = 1'b1;
      tap(6);
      scan(16'h0, 1, 0, 1'b0);

      // disable while a key is held; it is re-accepted after re-enable
      scans(16'(1) << 12, DS + 1);
      scan_off();
      scans(16'(1) << 12, DS + 1);
      scans(16'h0, DS);
      scan(16'h0, 2, 0, 1'b0);

      for (int s = 0; s < 30; s++) begin
         ty   = $urandom_range(0, 4);
         hold = $urandom_range(1, 5);
         k1   = $urandom_range(0, 15);
         k2   = (k1 + $urandom_range(1, 15)) % 16;
         irq_en = 1'($urandom_range(0, 1));
         if (ty == 0) m = 16'h0;
         else if (ty == 4) m = (16'(1) << k1) | (16'(1) << k2);
         else m = 16'(1) << k1;
         for (int h = 0; h < hold; h++)
            scan(m, $urandom_range(0, 1),
                 ($urandom_range(0, 6) == 0) ? 1 : 0,
                 1'($urandom_range(0, 3) == 0));
         if ($urandom_range(0, 9) == 0) scan_off();
      end
      scan(16'h0, 4, 1, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
